// File: rtl/bufmrce_ce_sequencer_if.sv
// Command/status bundle between a controller and the BUFMRCE CE sequencer.
interface bufmrce_ce_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  cmd;
    logic [15:0] cmd_len;
    logic        abort;
    logic        ce;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] ce_cycles;

    modport master (
        output req_valid, cmd, cmd_len, abort,
        input  req_ready, ce, busy, done, err, ce_cycles
    );

    modport slave (
        input  req_valid, cmd, cmd_len, abort,
        output req_ready, ce, busy, done, err, ce_cycles
    );
endinterface

// File: rtl/bufmrce_ce_sequencer.sv
// Drives a BUFMRCE CE pin (SYNC type) from run/stop/burst commands, holding off
// completion for a settle window after every CE edge.
//
// state        | meaning
// S_OFF        | CE=0, idle, accepting commands
// S_ON_SETTLE  | CE just rose, waiting SETTLE_CYCLES before DONE
// S_ON         | CE=1, idle, accepting commands
// S_BURST      | CE=1 for a counted number of cycles, ABORT honoured
// S_OFF_SETTLE | CE just fell, waiting SETTLE_CYCLES before DONE
module bufmrce_ce_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter bit          INIT_EN       = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    bufmrce_ce_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_OFF,
        S_ON_SETTLE,
        S_ON,
        S_BURST,
        S_OFF_SETTLE
    } state_t;

    localparam logic [1:0]  CMD_STOP  = 2'b00;
    localparam logic [1:0]  CMD_RUN   = 2'b01;
    localparam logic [1:0]  CMD_BURST = 2'b10;
    localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES);
    localparam state_t      RST_STATE = INIT_EN ? S_ON : S_OFF;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx;
    logic        ce_q, ce_nx;
    logic        done_q, done_nx;
    logic        err_q, err_nx;
    logic [15:0] ce_cycles_q;
    logic        ready;
    logic        accept;

    assign ready  = (state == S_OFF) || (state == S_ON);
    assign accept = bus.req_valid && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RST_STATE;
            cnt         <= '0;
            ce_q        <= INIT_EN;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ce_cycles_q <= '0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            ce_q   <= ce_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
            if (ce_q)
                ce_cycles_q <= ce_cycles_q + 16'd1;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ce_nx    = ce_q;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        case (state)
            S_OFF: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_RUN: begin
                            ce_nx    = 1'b1;
                            state_nx = S_ON_SETTLE;
                            cnt_nx   = SETTLE_LD;
                        end
                        CMD_BURST: begin
                            if (bus.cmd_len != 16'd0) begin
                                ce_nx    = 1'b1;
                                state_nx = S_BURST;
                                cnt_nx   = bus.cmd_len;
                            end else begin
                                done_nx = 1'b1;
                            end
                        end
                        CMD_STOP: done_nx = 1'b1;
                        default:  err_nx  = 1'b1;
                    endcase
                end
            end

            S_ON: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_STOP: begin
                            ce_nx    = 1'b0;
                            state_nx = S_OFF_SETTLE;
                            cnt_nx   = SETTLE_LD;
                        end
                        CMD_RUN: done_nx = 1'b1;
                        default: err_nx  = 1'b1;
                    endcase
                end
            end

            S_ON_SETTLE: begin
                cnt_nx = cnt - 16'd1;
                if (cnt <= 16'd1) begin
                    state_nx = S_ON;
                    done_nx  = 1'b1;
                end
            end

            // ABORT on the final edge lands in the same place as normal expiry.
            S_BURST: begin
                cnt_nx = cnt - 16'd1;
                if (bus.abort || cnt <= 16'd1) begin
                    ce_nx    = 1'b0;
                    state_nx = S_OFF_SETTLE;
                    cnt_nx   = SETTLE_LD;
                end
            end

            S_OFF_SETTLE: begin
                cnt_nx = cnt - 16'd1;
                if (cnt <= 16'd1) begin
                    state_nx = S_OFF;
                    done_nx  = 1'b1;
                end
            end

            default: begin
                state_nx = S_OFF;
                ce_nx    = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.req_ready = ready;
    assign bus.ce        = ce_q;
    assign bus.busy      = (state == S_ON_SETTLE) || (state == S_BURST) || (state == S_OFF_SETTLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.ce_cycles = ce_cycles_q;

endmodule
